parity_frame_tx: RTL and testbench

PARITY_FRAME_TX -- requirements
Module: parity_frame_tx

---
 rtl/parity_frame_pkg.sv | 25 ++
 rtl/bit_timer.sv | 39 +++
 rtl/parity_frame_tx.sv | 119 +++++++++++
 tb/tb_parity_frame_tx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_frame_pkg.sv
// Shared types, sizes and parity helper for the parity frame transmitter.
package parity_frame_pkg;

    localparam int unsigned FRAME_BITS = 7;
    localparam int unsigned DATA_BITS  = 4;
    localparam int unsigned BIT_IDX_W  = 2;
    localparam int unsigned CNT_W      = 8;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    // Parity bit so that payload plus parity has even (mode 0) or odd (mode 1) weight.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] d, input logic mode);
        return (mode == PARITY_EVEN) ? (^d) : ~(^d);
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Per-bit cycle counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module bit_timer
    import parity_frame_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_end
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: hold at zero while restarting, wrap at the bit boundary.
    always_comb begin
        cnt_d = cnt_q;
        if (restart || (cnt_q == LAST_CNT)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end = !restart && (cnt_q == LAST_CNT);

endmodule

// File: rtl/parity_frame_tx.sv
// Serial transmitter: start, 4 data bits LSB first, parity, stop; one word per frame.
module parity_frame_tx
    import parity_frame_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 parity_mode,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx_out,
    output logic                 busy,
    output logic                 done
);

    localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(DATA_BITS - 1);

    state_e               state_q;
    state_e               state_d;
    logic [BIT_IDX_W-1:0] bit_idx_q;
    logic [BIT_IDX_W-1:0] bit_idx_d;
    logic [DATA_BITS-1:0] data_q;
    logic [DATA_BITS-1:0] data_d;
    logic                 par_q;
    logic                 par_d;

    logic                 timer_restart;
    logic                 bit_end;

    assign timer_restart = (state_q == IDLE);

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (timer_restart),
        .bit_end (bit_end)
    );

    // Next-state, bit index and payload capture.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        par_d     = par_q;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    state_d   = START;
                    data_d    = data;
                    par_d     = calc_parity(data, parity_mode);
                    bit_idx_d = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == LAST_IDX) begin
                        state_d   = PARITY;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and frame registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            par_q     <= par_d;
        end
    end

    // Line level decoded from registered state only.
    always_comb begin
        tx_out = 1'b1;
        case (state_q)
            START:   tx_out = 1'b0;
            DATA:    tx_out = data_q[bit_idx_q];
            PARITY:  tx_out = par_q;
            default: tx_out = 1'b1;
        endcase
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == STOP) && bit_end;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Scoreboard bench for parity_frame_tx (CLKS_PER_BIT=4 main instance, =1 second instance).
module tb_parity_frame_tx;

    localparam int unsigned CPB       = 4;
    localparam int unsigned FRAME_CYC = 7 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] data = 4'h0;
    logic       parity_mode = 1'b0;
    logic       valid = 1'b0;
    logic       ready, tx_out, busy, done;

    logic [3:0] data1 = 4'h0;
    logic       mode1 = 1'b0;
    logic       valid1 = 1'b0;
    logic       ready1, tx1, busy1, done1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [6:0] exp_q[$];
    int         acc_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    parity_frame_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .data(data), .parity_mode(parity_mode), .valid(valid),
        .ready(ready), .tx_out(tx_out), .busy(busy), .done(done)
    );

    parity_frame_tx #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst), .data(data1), .parity_mode(mode1), .valid(valid1),
        .ready(ready1), .tx_out(tx1), .busy(busy1), .done(done1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected line sequence, bit i = i-th transmitted bit.
    function automatic logic [6:0] model_frame(input logic [3:0] d, input logic m);
        logic p;
        p = (^d) ^ m;
        return {1'b1, p, d, 1'b0};
    endfunction

    // Monitor: pops the expected frame at acceptance and checks every cycle of it.
    initial begin
        logic [6:0] f;
        forever begin
            @(negedge clk);
            if (!rst && valid && ready) begin
                acc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_accept", 32'(1), 32'(0));
                end else begin
                    f = exp_q.pop_front();
                    for (int c = 1; c <= int'(FRAME_CYC); c++) begin
                        @(negedge clk);
                        if (rst) break;
                        check_eq("tx_bit", 32'(tx_out), 32'(f[(c-1)/int'(CPB)]));
                        check_eq("done", 32'(done), 32'(c == int'(FRAME_CYC)));
                        check_eq("busy", 32'(busy), 32'(1));
                        check_eq("ready_in_frame", 32'(ready), 32'(0));
                    end
                end
            end else if (!rst && ready) begin
                check_eq("idle_tx", 32'(tx_out), 32'(1));
                check_eq("idle_busy", 32'(busy), 32'(0));
                check_eq("idle_done", 32'(done), 32'(0));
            end
        end
    end

    task automatic send(input logic [3:0] d, input logic m, input bit keep);
        bit ok;
        ok = 1'b0;
        data = d;
        parity_mode = m;
        valid = 1'b1;
        exp_q.push_back(model_frame(d, m));
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ready && !rst) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!keep) valid = 1'b0;
        if (!ok) check_eq("accept_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!ok) check_eq("idle_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        logic [5:0] tbl [4];
        logic [5:0] t;
        logic [6:0] seq1;
        int         done_at;
        int         n0;

        // {data, mode, expected parity bit}
        tbl[0] = {4'b0110, 1'b0, 1'b0};
        tbl[1] = {4'b0110, 1'b1, 1'b1};
        tbl[2] = {4'b1111, 1'b0, 1'b0};
        tbl[3] = {4'b0001, 1'b1, 1'b0};
        seq1   = 7'b1010010;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("rst_ready", 32'(ready), 32'(1));
        check_eq("rst_tx", 32'(tx_out), 32'(1));
        check_eq("rst_busy", 32'(busy), 32'(0));
        check_eq("rst_done", 32'(done), 32'(0));
        check_eq("rst_tx1", 32'(tx1), 32'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Single frames: parity value and done timing
        for (int i = 0; i < 4; i++) begin
            t = tbl[i];
            send(t[5:2], t[1], 1'b0);
            done_at = 0;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                if (k == 22) check_eq("parity_bit", 32'(tx_out), 32'(t[0]));
                if (done) begin
                    done_at = k;
                    break;
                end
            end
            check_eq("done_cycle", 32'(done_at), 32'(28));
            @(posedge clk);
            #1;
        end

        // Back-to-back with valid held high
        n0 = acc_q.size();
        send(4'b1010, 1'b0, 1'b1);
        send(4'b0101, 1'b0, 1'b0);
        wait_idle();
        if (acc_q.size() >= n0 + 2)
            check_eq("b2b_spacing", 32'(acc_q[n0+1] - acc_q[n0]), 32'(FRAME_CYC + 1));
        else
            check_eq("b2b_accepts", 32'(acc_q.size() - n0), 32'(2));

        // Inputs toggled mid-frame
        send(4'b1100, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) begin
            data = ~data;
            parity_mode = ~parity_mode;
            @(posedge clk);
            #1;
        end
        wait_idle();

        // Reset during data bit 2, valid asserted throughout reset
        send(4'b0011, 1'b0, 1'b0);
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        valid = 1'b1;
        data = 4'b1111;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("abort_tx", 32'(tx_out), 32'(1));
        check_eq("abort_busy", 32'(busy), 32'(0));
        check_eq("abort_done", 32'(done), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", 32'(ready), 32'(1));
        check_eq("post_rst_busy", 32'(busy), 32'(0));
        check_eq("post_rst_tx", 32'(tx_out), 32'(1));
        @(posedge clk);
        #1;
        send(4'b1001, 1'b1, 1'b0);
        wait_idle();

        // CLKS_PER_BIT = 1 instance
        data1 = 4'b1001;
        mode1 = 1'b0;
        valid1 = 1'b1;
        @(negedge clk);
        check_eq("cpb1_ready", 32'(ready1), 32'(1));
        @(posedge clk);
        #1;
        valid1 = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            check_eq("cpb1_tx", 32'(tx1), 32'(seq1[c-1]));
            check_eq("cpb1_done", 32'(done1), 32'(c == 7));
            check_eq("cpb1_busy", 32'(busy1), 32'(1));
        end
        @(negedge clk);
        check_eq("cpb1_ready_after", 32'(ready1), 32'(1));
        check_eq("cpb1_tx_idle", 32'(tx1), 32'(1));

        repeat (3) @(posedge clk);
        check_eq("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
